// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings and default latencies for the HI/LO multiply/divide unit.
// Rev 1.0
`default_nettype none

package mdu_pkg;

   typedef enum logic [1:0] {
      MD_MULT  = 2'd0,
      MD_MULTU = 2'd1,
      MD_DIV   = 2'd2,
      MD_DIVU  = 2'd3
   } md_op_e;

   localparam logic RD_LO = 1'b0;
   localparam logic RD_HI = 1'b1;

   localparam int DEF_MULT_CYCLES = 5;
   localparam int DEF_DIV_CYCLES  = 10;

   function automatic int max_int(input int x, input int y);
      return (x > y) ? x : y;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_arith.sv
// mdu_arith: single-cycle combinational multiply/divide on the latched operands.
// Rev 1.0
`default_nettype none

module mdu_arith
   import mdu_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  md_op_e      op_i,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        div0_o
);

   logic signed [63:0] prod_s;
   logic        [63:0] prod_u;
   logic        [31:0] b_safe;
   logic signed [31:0] quo_s;
   logic signed [31:0] rem_s;
   logic        [31:0] quo_u;
   logic        [31:0] rem_u;
   logic               ovf;

   always_comb begin
      ovf    = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
      // Keep the divider away from /0 and the -2^31/-1 trap; both cases are overridden below.
      b_safe = ((b_i == 32'd0) || ovf) ? 32'd1 : b_i;
      prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
      prod_u = {32'd0, a_i} * {32'd0, b_i};
      quo_s  = $signed(a_i) / $signed(b_safe);
      rem_s  = $signed(a_i) % $signed(b_safe);
      quo_u  = a_i / b_safe;
      rem_u  = a_i % b_safe;
      div0_o = op_i[1] && (b_i == 32'd0);

      hi_o = 32'd0;
      lo_o = 32'd0;
      case (op_i)
         MD_MULT: begin
            hi_o = prod_s[63:32];
            lo_o = prod_s[31:0];
         end
         MD_MULTU: begin
            hi_o = prod_u[63:32];
            lo_o = prod_u[31:0];
         end
         MD_DIV: begin
            if (ovf) begin
               hi_o = 32'd0;
               lo_o = 32'h8000_0000;
            end else begin
               hi_o = rem_s;
               lo_o = quo_s;
            end
         end
         MD_DIVU: begin
            hi_o = rem_u;
            lo_o = quo_u;
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/mdu_hilo.sv
// mdu_hilo: HI/LO register pair with start/busy multiply/divide handshake and mthi/mtlo/mfhi/mflo access.
// Rev 1.0
`default_nettype none

module mdu_hilo
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  md_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic        rd_sel,
   output logic        busy,
   output logic [31:0] rdata
);

   localparam int CNT_W = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);
   localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      a_q, a_d;
   logic [31:0]      b_q, b_d;
   md_op_e           op_q, op_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;

   logic [31:0]      hi_res;
   logic [31:0]      lo_res;
   logic             div0;

   mdu_arith u_arith (
      .a_i    (a_q),
      .b_i    (b_q),
      .op_i   (op_q),
      .hi_o   (hi_res),
      .lo_o   (lo_res),
      .div0_o (div0)
   );

   assign busy  = (count_q != '0);
   assign rdata = (rd_sel == RD_HI) ? hi_q : lo_q;

   always_comb begin
      count_d = count_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      hi_d    = hi_q;
      lo_d    = lo_q;

      if (!busy) begin
         // A launch wins over a same-edge mthi/mtlo, which is simply dropped.
         if (start) begin
            a_d     = A;
            b_d     = B;
            op_d    = md_op_e'(md_op);
            count_d = md_op[1] ? DIV_CNT : MULT_CNT;
         end else begin
            if (hi_we) hi_d = A;
            if (lo_we) lo_d = A;
         end
      end else if (count_q == CNT_ONE) begin
         count_d = '0;
         if (!div0) begin
            hi_d = hi_res;
            lo_d = lo_res;
         end
      end else begin
         count_d = count_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         op_q    <= MD_MULT;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         count_q <= count_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: scoreboard bench; stimulus queues expected HI/LO/busy-length, a monitor compares on run end or probe.
// Rev 1.0
`default_nettype none

module tb_mdu_hilo;
   import mdu_pkg::*;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  md_op;
   logic [31:0] A;
   logic [31:0] B;
   logic        hi_we;
   logic        lo_we;
   logic        rd_sel;
   logic        busy;
   logic [31:0] rdata;

   mdu_hilo #(
      .MULT_CYCLES (5),
      .DIV_CYCLES  (10)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .md_op  (md_op),
      .A      (A),
      .B      (B),
      .hi_we  (hi_we),
      .lo_we  (lo_we),
      .rd_sel (rd_sel),
      .busy   (busy),
      .rdata  (rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          n;      // expected busy cycles; 0 marks an idle probe
      logic [31:0] hi;
      logic [31:0] lo;
      string       tag;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   passed = 0;
   logic probe  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
   endtask

   // Monitor: counts busy cycles, compares HI/LO when a run ends or a probe is requested.
   initial begin : monitor
      int          run_cnt;
      logic [31:0] hi_v;
      logic [31:0] lo_v;
      exp_t        e;
      run_cnt = 0;
      rd_sel  = RD_LO;
      forever begin
         @(negedge clk);
         if (busy === 1'b1) begin
            run_cnt++;
         end else if (run_cnt > 0 || probe) begin
            rd_sel = RD_LO;
            #1 lo_v = rdata;
            rd_sel = RD_HI;
            #1 hi_v = rdata;
            rd_sel = RD_LO;
            if (q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_event: busy_cycles=%0d probe=%0b with empty queue", run_cnt, probe);
            end else begin
               e = q.pop_front();
               check({e.tag, "_busy_cycles"}, 32'(run_cnt), 32'(e.n));
               check({e.tag, "_hi"}, hi_v, e.hi);
               check({e.tag, "_lo"}, lo_v, e.lo);
            end
            run_cnt = 0;
         end
      end
   end

   task automatic push(input int n, input logic [31:0] hi, input logic [31:0] lo, input string tag);
      exp_t e;
      e.n = n; e.hi = hi; e.lo = lo; e.tag = tag;
      q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1; md_op = op; A = a; B = b;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int i;
      for (i = 0; i < 40 && busy; i++) tick();
      if (busy) begin
         checks++;
         $display("FAIL %s_timeout: busy still 1 after 40 cycles, expected 0", tag);
      end
      tick();
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int n, input logic [31:0] hi, input logic [31:0] lo, input string tag);
      push(n, hi, lo, tag);
      launch(op, a, b);
      wait_idle(tag);
   endtask

   task automatic do_probe(input logic [31:0] hi, input logic [31:0] lo, input string tag);
      push(0, hi, lo, tag);
      probe = 1'b1;
      tick();
      probe = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation still running at 200000, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      reset = 1'b1; start = 1'b0; md_op = 2'd0; A = '0; B = '0; hi_we = 1'b0; lo_we = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      tick();
      do_probe(32'h0, 32'h0, "reset_idle");

      run_op(MD_MULT,  32'hFFFF_FFFE, 32'd3, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_neg");
      run_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 5,  32'h0000_0002, 32'hFFFF_FFFA, "multu");
      run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
      run_op(MD_DIVU,  32'd7,         32'd2, 10, 32'd1,         32'd3,         "divu");
      run_op(MD_DIV,   32'd7,  32'hFFFF_FFFE, 10, 32'd1,         32'hFFFF_FFFD, "div_negdivisor");
      run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000, "div_ovf");

      hi_we = 1'b1; A = 32'h1234; tick(); hi_we = 1'b0;
      lo_we = 1'b1; A = 32'h5678; tick(); lo_we = 1'b0;
      do_probe(32'h1234, 32'h5678, "mt_preload");
      run_op(MD_DIV,  32'd99, 32'd0, 10, 32'h1234, 32'h5678, "div_by0");
      run_op(MD_DIVU, 32'd99, 32'd0, 10, 32'h1234, 32'h5678, "divu_by0");

      hi_we = 1'b1; lo_we = 1'b1; A = 32'hABCD; tick(); hi_we = 1'b0; lo_we = 1'b0;
      do_probe(32'hABCD, 32'hABCD, "mt_both");

      // start and mthi on the same idle edge: the mthi data (0x5) must never reach HI.
      push(5, 32'h0, 32'h23, "start_vs_mthi");
      hi_we = 1'b1;
      launch(MD_MULT, 32'd5, 32'd7);
      hi_we = 1'b0;
      wait_idle("start_vs_mthi");

      // start and mtlo while busy are ignored; operands must come from the latched copies.
      push(5, 32'h1, 32'h0, "busy_ignore");
      launch(MD_MULTU, 32'h0001_0000, 32'h0001_0000);
      tick();
      start = 1'b1; lo_we = 1'b1; md_op = MD_DIV; A = 32'd9; B = 32'd3;
      tick();
      start = 1'b0; lo_we = 1'b0; A = 32'hDEAD_BEEF; B = 32'h1;
      wait_idle("busy_ignore");

      // Reset mid-divide: four busy cycles, then everything cleared and no late write.
      push(4, 32'h0, 32'h0, "reset_abort");
      launch(MD_DIV, 32'd100, 32'd7);
      repeat (3) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (10) tick();
      do_probe(32'h0, 32'h0, "no_late_write");

      for (int i = 0; i < 50 && q.size() > 0; i++) tick();
      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         checks++;
         $display("FAIL %s_missing: event not observed, expected busy_cycles=%0d", e.tag, e.n);
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
Multiply/divide unit holding the HI/LO architectural pair for the P6 pipeline. It sits in the EX stage beside the ALU and accepts mult/multu/div/divu through a start/busy handshake. It also accepts mthi/mtlo writes and serves mfhi/mflo reads. It is the register-file counterpart to the GRF: the hazard unit stalls mdu-class instructions in D while start or busy is high.

Parameters:
MULT_CYCLES, 5, cycles busy stays high for mult/multu (>=1)
DIV_CYCLES, 10, cycles busy stays high for div/divu (>=1)

Ports:
clk  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high; clears all state
start  input  1  launch op on this edge (sampled only when busy=0)
md_op  input  2  0=mult, 1=multu, 2=div, 3=divu; valid with start
A  input  32  rs operand (multiplicand/dividend, or mthi/mtlo data)
B  input  32  rt operand (multiplier/divisor)
hi_we  input  1  mthi: write A into HI
lo_we  input  1  mtlo: write A into LO
rd_sel  input  1  0=output LO (mflo), 1=output HI (mfhi)
busy  output  1  operation in flight
rdata  output  32  rd_sel ? HI : LO, combinational from registers

Behaviour:
- Reset: HI=0, LO=0, count=0, busy=0, latched operands/op=0. Reset mid-operation aborts the op; its result is never written.
- State: idle (count==0) and run (count>0); busy = (count != 0).
- Launch at an edge with start=1 and busy=0:
  - latch A, B and md_op;
  - count <= MULT_CYCLES for md_op 0/1, or DIV_CYCLES for md_op 2/3.
- Run:
  - each edge with count>1: count decrements;
  - edge with count==1: HI/LO are written, count <= 0.
- Timing: busy is high for exactly N cycles after the launch edge. The new HI/LO are visible on rdata in the first cycle busy=0.
- Result computation:
  - Operands are taken from the latched copies, never the live inputs.
  - mult: signed 64-bit product; HI = [63:32], LO = [31:0].
  - multu: unsigned 64-bit product; same HI/LO split.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient in LO, unsigned remainder in HI.
  - div with 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Divide by zero (B==0, div or divu): the run completes with normal busy timing, but HI and LO stay unchanged.
- Ignored inputs (no state change):
  - start while busy=1 (the hazard unit guarantees this does not occur);
  - hi_we/lo_we while busy=1.
- Same edge, busy=0: start has priority over hi_we/lo_we; the mt write is dropped.
- Same edge, busy=0, hi_we and lo_we both high: both registers take A.
- rdata during run shows the old HI/LO. A read-after-write is resolved by the stall, not by forwarding inside this block.
- Arithmetic may be a single-cycle combinational multiply/divide on the latched operands. Only the handshake timing is multi-cycle.

Decomposition:
- Shared package mdu_pkg holds:
  - md_op encodings MD_MULT=2'd0, MD_MULTU=2'd1, MD_DIV=2'd2, MD_DIVU=2'd3;
  - RD_LO=1'b0, RD_HI=1'b1;
  - default cycle counts.
- The controller/decoder uses the package to drive md_op.
- One natural sub-module: mdu_arith, a purely combinational block (latched A, B, op -> hi_res, lo_res, div0). mdu_hilo keeps the counter, registers and handshake.

Test Plan:
- Reset then idle: rdata=0 for both rd_sel; busy=0.
- mult, A=0xFFFFFFFE (-2), B=3 at cycle 0:
  - busy high for cycles 1..5;
  - cycle 6: HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - Same operands with multu: HI=0x00000002, LO=0xFFFFFFFA.
- div, A=0xFFFFFFF9 (-7), B=2: busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu, A=7, B=2: LO=3, HI=1.
- Preload with mthi A=0x1234 and mtlo A=0x5678, then div with B=0: busy for 10 cycles; HI=0x1234, LO=0x5678 afterwards.
- start plus mthi on the same idle edge: mult result written; the mthi value never appears.
  - start and mtlo on cycle 3 of a run: ignored; the final result matches the original op.
- reset asserted at cycle 4 of a div: next cycle busy=0 and HI=LO=0; no late write occurs at cycle 10.
